mode_control: RTL

Front-panel controller for the clock/timer/stopwatch system. It conditions three raw push-buttons and owns the mode register `rezhim`, which the clock, timer and stopwatch blocks consume. It routes each button press to the active block. It runs the field-by-field time-setting sequence that loads the clock or timer through their setup ports, and it selects and blinks the 24-bit value sent to the display driver.

---
 rtl/chasy_pkg.sv | 35 +++
 rtl/mode_control_if.sv | 28 ++
 rtl/button_cond.sv | 50 +++++
 rtl/mode_control.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/chasy_pkg.sv
// Shared types and constants for the clock/timer/stopwatch front panel.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package chasy_pkg;

  typedef enum logic [1:0] {
    MODE_CLOCK     = 2'd0,
    MODE_TIMER     = 2'd1,
    MODE_STOPWATCH = 2'd2
  } mode_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    EDIT_H = 2'd1,
    EDIT_M = 2'd2,
    EDIT_S = 2'd3
  } edit_state_t;

  localparam logic [7:0] HOUR_MAX   = 8'd23;
  localparam logic [7:0] MINSEC_MAX = 8'd59;

  // {hh, mm, ss} field positions inside a 24-bit time word
  localparam int HH_MSB = 23;
  localparam int HH_LSB = 16;
  localparam int MM_MSB = 15;
  localparam int MM_LSB = 8;
  localparam int SS_MSB = 7;
  localparam int SS_LSB = 0;

  // Wrapping field increment; anything already at or past max restarts at 0
  function automatic logic [7:0] field_inc(input logic [7:0] val, input logic [7:0] max);
    return (val >= max) ? 8'd0 : val + 8'd1;
  endfunction

endpackage

// File: rtl/mode_control_if.sv
// Data and control bundle between the front panel and the time-keeping blocks.
// Latency: n/a (wires only).
// Backpressure: none; all strobes are single-cycle pulses.
interface mode_control_if;
  logic [23:0] clock_data;
  logic [23:0] timer_data;
  logic [23:0] stopwatch_data;
  logic [1:0]  rezhim;
  logic        button_start_stop;
  logic        button_reset;
  logic        setup_imp;
  logic        setup_target;
  logic [23:0] setup_data;
  logic [23:0] disp_data;
  logic [2:0]  disp_blank;

  modport master (
    input  clock_data, timer_data, stopwatch_data,
    output rezhim, button_start_stop, button_reset,
           setup_imp, setup_target, setup_data, disp_data, disp_blank
  );

  modport slave (
    output clock_data, timer_data, stopwatch_data,
    input  rezhim, button_start_stop, button_reset,
           setup_imp, setup_target, setup_data, disp_data, disp_blank
  );
endinterface

// File: rtl/button_cond.sv
// Raw push-button conditioner: 2-flop sync, stability debounce, rising-edge press pulse.
// Latency: 2 sync cycles + DEB_CYCLES stable samples before the press pulse.
// Backpressure: none; press is a one-cycle pulse, releases produce nothing.
module button_cond #(
  parameter int DEB_CYCLES = 500000
) (
  input  logic clock,
  input  logic reset,
  input  logic btn,
  output logic press
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q;
  logic          level_q;
  logic          level_prev_q;

  // bring the asynchronous button into the clock domain
  always_ff @(posedge clock) begin
    if (reset) sync_q <= 2'b00;
    else       sync_q <= {sync_q[0], btn};
  end

  // accept a new level only after DEB_CYCLES consecutive samples disagree with the current one
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else if (sync_q[1] == level_q) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_q   <= '0;
      level_q <= sync_q[1];
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // remember last debounced level for edge detection
  always_ff @(posedge clock) begin
    if (reset) level_prev_q <= 1'b0;
    else       level_prev_q <= level_q;
  end

  assign press = level_q & ~level_prev_q;

endmodule

// File: rtl/mode_control.sv
// Front-panel controller: mode register, press routing, field-by-field time setup, display select/blink.
// Latency: action pulses and state updates register one cycle after the debounced press pulse.
// Backpressure: none; one press per cycle is honoured (mode > b > a), the rest are dropped.
module mode_control #(
  parameter int DEB_CYCLES = 500000,
  parameter int BLINK_HALF = 25000000
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           btn_mode,
  input  logic           btn_a,
  input  logic           btn_b,
  mode_control_if.master bus
);
  import chasy_pkg::*;

  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

  logic press_mode, press_a, press_b;
  logic do_mode, do_a, do_b;

  edit_state_t state_q, state_d;
  logic [1:0]  rezhim_q, rezhim_d;
  logic [23:0] edit_buf_q, edit_buf_d;
  logic [23:0] setup_data_q, setup_data_d;
  logic        target_q, target_d;
  logic        start_stop_q, start_stop_d;
  logic        reset_pulse_q, reset_pulse_d;
  logic        imp_q, imp_d;
  logic [BW-1:0] blink_cnt_q;
  logic        blink_off_q;

  button_cond #(.DEB_CYCLES(DEB_CYCLES)) u_btn_mode (.clock(clock), .reset(reset), .btn(btn_mode), .press(press_mode));
  button_cond #(.DEB_CYCLES(DEB_CYCLES)) u_btn_a    (.clock(clock), .reset(reset), .btn(btn_a),    .press(press_a));
  button_cond #(.DEB_CYCLES(DEB_CYCLES)) u_btn_b    (.clock(clock), .reset(reset), .btn(btn_b),    .press(press_b));

  assign do_mode = press_mode;
  assign do_b    = press_b & ~press_mode;
  assign do_a    = press_a & ~press_mode & ~press_b;

  // state and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= RUN;
      rezhim_q      <= MODE_CLOCK;
      edit_buf_q    <= '0;
      setup_data_q  <= '0;
      target_q      <= 1'b0;
      start_stop_q  <= 1'b0;
      reset_pulse_q <= 1'b0;
      imp_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      rezhim_q      <= rezhim_d;
      edit_buf_q    <= edit_buf_d;
      setup_data_q  <= setup_data_d;
      target_q      <= target_d;
      start_stop_q  <= start_stop_d;
      reset_pulse_q <= reset_pulse_d;
      imp_q         <= imp_d;
    end
  end

  // next state: route the winning press according to mode and edit state
  always_comb begin
    state_d       = state_q;
    rezhim_d      = rezhim_q;
    edit_buf_d    = edit_buf_q;
    setup_data_d  = setup_data_q;
    target_d      = target_q;
    start_stop_d  = 1'b0;
    reset_pulse_d = 1'b0;
    imp_d         = 1'b0;
    if (state_q == RUN) begin
      if (do_mode) begin
        case (rezhim_q)
          MODE_CLOCK: rezhim_d = MODE_TIMER;
          MODE_TIMER: rezhim_d = MODE_STOPWATCH;
          default:    rezhim_d = MODE_CLOCK;
        endcase
      end else if (do_b) begin
        if (rezhim_q == MODE_STOPWATCH) begin
          reset_pulse_d = 1'b1;
        end else if (rezhim_q != 2'd3) begin
          // snapshot is taken once; the source keeps running underneath
          edit_buf_d = rezhim_q[0] ? bus.timer_data : bus.clock_data;
          target_d   = rezhim_q[0];
          state_d    = EDIT_H;
        end
      end else if (do_a && rezhim_q == MODE_STOPWATCH) begin
        start_stop_d = 1'b1;
      end
    end else begin
      if (do_mode) begin
        state_d = RUN;
      end else if (do_b) begin
        if (state_q == EDIT_H) begin
          state_d = EDIT_M;
        end else if (state_q == EDIT_M) begin
          state_d = EDIT_S;
        end else begin
          setup_data_d = edit_buf_q;
          imp_d        = 1'b1;
          state_d      = RUN;
        end
      end else if (do_a) begin
        if (state_q == EDIT_H)
          edit_buf_d[HH_MSB:HH_LSB] = field_inc(edit_buf_q[HH_MSB:HH_LSB], HOUR_MAX);
        else if (state_q == EDIT_M)
          edit_buf_d[MM_MSB:MM_LSB] = field_inc(edit_buf_q[MM_MSB:MM_LSB], MINSEC_MAX);
        else
          edit_buf_d[SS_MSB:SS_LSB] = field_inc(edit_buf_q[SS_MSB:SS_LSB], MINSEC_MAX);
      end
    end
  end

  // blink timer restarts in the visible half on every edit-state entry
  always_ff @(posedge clock) begin
    if (reset || state_q == RUN || state_d != state_q) begin
      blink_cnt_q <= '0;
      blink_off_q <= 1'b0;
    end else if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_q <= '0;
      blink_off_q <= ~blink_off_q;
    end else begin
      blink_cnt_q <= blink_cnt_q + 1'b1;
    end
  end

  assign bus.rezhim            = rezhim_q;
  assign bus.button_start_stop = start_stop_q;
  assign bus.button_reset      = reset_pulse_q;
  assign bus.setup_imp         = imp_q;
  assign bus.setup_target      = target_q;
  assign bus.setup_data        = setup_data_q;

  // display: live source in RUN, frozen edit buffer with blinking field in edit
  always_comb begin
    bus.disp_data  = bus.clock_data;
    bus.disp_blank = 3'b000;
    if (state_q != RUN) begin
      bus.disp_data  = edit_buf_q;
      bus.disp_blank = {(state_q == EDIT_H) & blink_off_q,
                        (state_q == EDIT_M) & blink_off_q,
                        (state_q == EDIT_S) & blink_off_q};
    end else if (rezhim_q == MODE_TIMER) begin
      bus.disp_data = bus.timer_data;
    end else if (rezhim_q == MODE_STOPWATCH) begin
      bus.disp_data = bus.stopwatch_data;
    end
  end

endmodule
